// File: rtl/disp_pkg.sv
// Shared types and frame-size helpers for the display VRAM read path.
package disp_pkg;

  typedef enum logic [1:0] {
    ResVga  = 2'b00,
    ResXga  = 2'b01,
    ResSxga = 2'b10,
    ResRsvd = 2'b11
  } resol_t;

  localparam int unsigned PIX_VGA  = 640 * 480;
  localparam int unsigned PIX_XGA  = 1024 * 768;
  localparam int unsigned PIX_SXGA = 1280 * 1024;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVs,
    StHold,
    StReq,
    StDone,
    StDrain
  } rdctrl_state_e;

  // The reserved resolution code falls back to VGA.
  function automatic logic [16:0] bursts_per_frame(resol_t resol, int unsigned burst_len);
    int unsigned pix;
    case (resol)
      ResXga:  pix = PIX_XGA;
      ResSxga: pix = PIX_SXGA;
      default: pix = PIX_VGA;
    endcase
    return 17'(pix / burst_len);
  endfunction

endpackage

// File: rtl/disp_rdctrl.sv
// VRAM read-request sequencer: paces AXI AR bursts over one display frame.
// Defining DISP_RDCTRL_IRQ_EN adds the FRAME_DONE completion pulse.
module disp_rdctrl
  import disp_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned MAX_OUTSTD = 4,
  parameter int unsigned FIFO_AW    = 9
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             DISPON,
  input  logic [31:0]      DISPADDR,
  input  logic [1:0]       RESOL,
  input  logic             VSTART,
  input  logic [FIFO_AW:0] FIFO_FREE,
  input  logic             RLAST_DONE,
  input  logic             ERR_CLR,
  output logic [31:0]      ARADDR,
  output logic [7:0]       ARLEN,
  output logic             ARVALID,
  input  logic             ARREADY,
  output logic             BUSY,
`ifdef DISP_RDCTRL_IRQ_EN
  output logic             FRAME_DONE,
`endif
  output logic             FRAME_LATE
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTD + 1);

  rdctrl_state_e   state_q, state_d;
  logic [31:0]     base_q, base_d;
  logic [16:0]     left_q, left_d;
  logic [16:0]     idx_q, idx_d;
  logic [OutW-1:0] outstd_q, outstd_d;
  logic            arvalid_q, arvalid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic            restart_q, restart_d;
  logic            late_q, late_d;

  logic ar_hs, rl_dec, can_issue, latch, set_late, last_hs;

  assign ar_hs     = arvalid_q & ARREADY;
  assign rl_dec    = RLAST_DONE & (outstd_q != '0);
  assign can_issue = (32'(outstd_q) < MAX_OUTSTD) &&
                     (32'(FIFO_FREE) >= (32'(outstd_q) + 32'd1) * BURST_LEN);

  always_comb begin
    outstd_d = outstd_q;
    if (ar_hs && !rl_dec) begin
      outstd_d = outstd_q + OutW'(1);
    end else if (!ar_hs && rl_dec) begin
      outstd_d = outstd_q - OutW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    left_d    = left_q;
    idx_d     = idx_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    restart_d = restart_q;
    latch     = 1'b0;
    set_late  = 1'b0;
    last_hs   = 1'b0;

    case (state_q)
      StIdle: begin
        if (DISPON) state_d = StWaitVs;
      end
      StWaitVs, StDone: begin
        if (!DISPON) begin
          state_d = StDrain;
        end else if (VSTART) begin
          latch   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!DISPON) begin
          state_d = StDrain;
        end else if (VSTART) begin
          latch    = 1'b1;
          set_late = 1'b1;
        end else if (can_issue) begin
          state_d   = StReq;
          arvalid_d = 1'b1;
          araddr_d  = base_q + 32'(idx_q) * (BURST_LEN * 4);
        end
      end
      StReq: begin
        if (VSTART) begin
          latch    = 1'b1;
          set_late = 1'b1;
        end
        if (ar_hs) begin
          arvalid_d = 1'b0;
          restart_d = 1'b0;
          state_d   = StHold;
          // A handshake that races a restart still belongs to the old frame.
          if (!VSTART && !restart_q) begin
            idx_d  = idx_q + 17'd1;
            left_d = left_q - 17'd1;
            if (left_q == 17'd1) begin
              state_d = StDone;
              last_hs = 1'b1;
            end
          end
          if (!DISPON) state_d = StDrain;
        end else if (VSTART) begin
          restart_d = 1'b1;
        end
      end
      StDrain: begin
        if (outstd_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (latch) begin
      base_d = DISPADDR & 32'hFFFF_FFC0;
      left_d = bursts_per_frame(resol_t'(RESOL), BURST_LEN);
      idx_d  = '0;
    end
    late_d = (late_q & ~ERR_CLR) | set_late;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      base_q    <= '0;
      left_q    <= '0;
      idx_q     <= '0;
      outstd_q  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      restart_q <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      left_q    <= left_d;
      idx_q     <= idx_d;
      outstd_q  <= outstd_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      restart_q <= restart_d;
      late_q    <= late_d;
    end
  end

`ifdef DISP_RDCTRL_IRQ_EN
  logic last_pend_q, last_pend_d, done_q, done_d;

  always_comb begin
    last_pend_d = last_pend_q | last_hs;
    done_d      = 1'b0;
    if (last_pend_d && outstd_d == '0) begin
      done_d      = 1'b1;
      last_pend_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      last_pend_q <= last_pend_d;
      done_q      <= done_d;
    end
  end

  assign FRAME_DONE = done_q;
`else
  logic unused_last_hs;
  assign unused_last_hs = last_hs;
`endif

  assign ARADDR     = araddr_q;
  assign ARVALID    = arvalid_q;
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign FRAME_LATE = late_q;
  assign BUSY       = (state_q != StIdle && state_q != StWaitVs) || (outstd_q != '0);

endmodule

// File: tb/tb_disp_rdctrl.sv
// Scoreboard bench for disp_rdctrl: expected AR addresses come from a frame-level model.
module tb_disp_rdctrl;

  logic        ACLK = 1'b0;
  logic        ARESET, DISPON, VSTART, RLAST_DONE, ERR_CLR, ARREADY;
  logic [31:0] DISPADDR;
  logic [1:0]  RESOL;
  logic [9:0]  FIFO_FREE;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, BUSY, FRAME_LATE;
`ifdef DISP_RDCTRL_IRQ_EN
  logic        FRAME_DONE;
`endif

  always #5 ACLK = ~ACLK;

  disp_rdctrl dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .DISPON     (DISPON),
    .DISPADDR   (DISPADDR),
    .RESOL      (RESOL),
    .VSTART     (VSTART),
    .FIFO_FREE  (FIFO_FREE),
    .RLAST_DONE (RLAST_DONE),
    .ERR_CLR    (ERR_CLR),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .BUSY       (BUSY),
`ifdef DISP_RDCTRL_IRQ_EN
    .FRAME_DONE (FRAME_DONE),
`endif
    .FRAME_LATE (FRAME_LATE)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int unsigned due_q[$];
  int unsigned cyc = 0;
  int          hs_cnt = 0;
  int          man_req = 0;
  int          man_done = 0;
  bit          rl_auto = 1'b0;
  logic [31:0] last_hs_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Frame model: one burst per BURST_LEN pixels, 64-byte stride from the aligned base.
  function automatic void push_frame(input logic [31:0] addr, input logic [1:0] res);
    int unsigned pix;
    pix = (res == 2'b01) ? 1024 * 768 : (res == 2'b10) ? 1280 * 1024 : 640 * 480;
    for (int unsigned k = 0; k < pix / 16; k++) begin
      exp_q.push_back((addr & 32'hFFFF_FFC0) + k * 64);
    end
  endfunction

  // A frame start lets a request already on the bus complete; everything else is dropped.
  task automatic start_frame(input logic [31:0] addr, input logic [1:0] res);
    logic [31:0] head;
    if (ARVALID && exp_q.size() > 0) begin
      head = exp_q[0];
      exp_q.delete();
      exp_q.push_back(head);
    end else begin
      exp_q.delete();
    end
    push_frame(addr, res);
    DISPADDR = addr;
    RESOL    = res;
    VSTART   = 1'b1;
    tick();
    VSTART   = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget && hs_cnt < target; i++) tick();
  endtask

  task automatic wait_arvalid(input string name);
    for (int i = 0; i < 20 && !ARVALID; i++) tick();
    check(name, ARVALID, 1'b1);
  endtask

  // Monitor: AR handshakes and AR hold-while-stalled.
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("arvalid_hold", ARVALID, 1'b1);
          check("araddr_hold", ARADDR, prev_addr);
        end
        if (ARVALID && ARREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ar: got 0x%08h, expected no request", ARADDR);
          end else begin
            check("araddr", ARADDR, exp_q.pop_front());
          end
          check("arlen", 32'(ARLEN), 32'd15);
          hs_cnt++;
          last_hs_addr = ARADDR;
          if (rl_auto) due_q.push_back(cyc + $urandom_range(4, 2));
        end
        prev_stall = ARVALID && !ARREADY;
        prev_addr  = ARADDR;
      end
    end
  end

  // Read-data return: manual pulses first, then scheduled ones.
  initial begin
    RLAST_DONE = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      cyc++;
      RLAST_DONE = 1'b0;
      if (man_req != man_done) begin
        RLAST_DONE = 1'b1;
        man_done++;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        RLAST_DONE = 1'b1;
      end
    end
  end

  initial begin
    int hs0;
    ARESET    = 1'b1;
    DISPON    = 1'b0;
    DISPADDR  = '0;
    RESOL     = 2'b00;
    VSTART    = 1'b0;
    FIFO_FREE = 10'd512;
    ERR_CLR   = 1'b0;
    ARREADY   = 1'b1;
    tick(3);
    check("rst_arvalid", ARVALID, 1'b0);
    check("rst_araddr", ARADDR, 32'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_frame_late", FRAME_LATE, 1'b0);
    check("rst_arlen", 32'(ARLEN), 32'd15);

    ARESET = 1'b0;
    DISPON = 1'b1;
    tick(2);
    check("wait_vs_busy", BUSY, 1'b0);

    // Full VGA frame, misaligned base must be forced to 64-byte alignment.
    rl_auto = 1'b1;
    start_frame(32'h2000_0015, 2'b00);
    wait_hs(1, 20);
    check("first_ar", last_hs_addr, 32'h2000_0000);
    wait_hs(19200, 45000);
    check("frame_ar_count", hs_cnt, 32'd19200);
    check("last_ar", last_hs_addr, 32'h2012_BFC0);
    tick(20);
    check("no_ar_after_frame", hs_cnt, 32'd19200);
    check("done_arvalid", ARVALID, 1'b0);
    check("done_busy", BUSY, 1'b1);
    check("frame_late_clean", FRAME_LATE, 1'b0);
    check("frame_queue_empty", exp_q.size(), 32'd0);

    // Withheld read data: outstanding limit caps at four requests.
    rl_auto = 1'b0;
    tick(10);
    hs0 = hs_cnt;
    start_frame($urandom, 2'($urandom));
    tick(40);
    check("withheld_ars", hs_cnt - hs0, 32'd4);
    check("withheld_arvalid", ARVALID, 1'b0);
    check("start_from_done_not_late", FRAME_LATE, 1'b0);
    man_req++;
    tick(30);
    check("one_more_ar", hs_cnt - hs0, 32'd5);

    // FIFO threshold: two outstanding needs 48 free words.
    FIFO_FREE = 10'd47;
    man_req += 2;
    tick(20);
    check("fifo47_no_ar", hs_cnt - hs0, 32'd5);
    check("fifo47_arvalid", ARVALID, 1'b0);
    ARREADY   = 1'b0;
    FIFO_FREE = 10'd48;
    tick();
    check("fifo48_arvalid", ARVALID, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_arvalid", ARVALID, 1'b1);
      check("stall_araddr", ARADDR, exp_q[0]);
    end
    ARREADY = 1'b1;
    tick(8);
    check("stall_one_handshake", hs_cnt - hs0, 32'd6);

    // Late frame start while a request waits on the bus.
    FIFO_FREE = 10'd512;
    ARREADY   = 1'b0;
    wait_arvalid("late_pre_arvalid");
    start_frame(32'h2010_0000, 2'($urandom));
    check("frame_late_set", FRAME_LATE, 1'b1);
    ARREADY = 1'b1;
    man_req += 4;
    rl_auto = 1'b1;
    hs0 = hs_cnt;
    wait_hs(hs0 + 2, 40);
    check("restart_addr", last_hs_addr, 32'h2010_0000);
    wait_hs(hs0 + 100, 600);
    check("late_frame_ars", hs_cnt - hs0, 32'd100);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("err_clr", FRAME_LATE, 1'b0);

    // Set and clear in the same cycle: set wins.
    wait_arvalid("simul_pre_arvalid");
    ERR_CLR = 1'b1;
    start_frame($urandom, 2'($urandom));
    ERR_CLR = 1'b0;
    check("set_beats_clear", FRAME_LATE, 1'b1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("err_clr_again", FRAME_LATE, 1'b0);
    for (int i = 0; i < 80; i++) begin
      ARREADY = 1'($urandom);
      tick();
    end
    ARREADY = 1'b1;

    // Display off with three outstanding: drain, then idle.
    FIFO_FREE = 10'd48;
    rl_auto   = 1'b0;
    tick(40);
    check("three_outstd_arvalid", ARVALID, 1'b0);
    DISPON    = 1'b0;
    FIFO_FREE = 10'd512;
    hs0       = hs_cnt;
    tick(20);
    check("drain_no_ar", hs_cnt - hs0, 32'd0);
    check("drain_busy", BUSY, 1'b1);
    man_req += 2;
    tick(10);
    check("drain_busy_two_back", BUSY, 1'b1);
    man_req++;
    tick(5);
    check("drain_idle_busy", BUSY, 1'b0);
    check("drain_still_no_ar", hs_cnt - hs0, 32'd0);

    // Stray returns with nothing outstanding must not disturb the count.
    man_req += 2;
    tick(5);
    DISPON    = 1'b1;
    FIFO_FREE = 10'd16;
    tick(2);
    hs0 = hs_cnt;
    start_frame($urandom, 2'($urandom));
    tick(20);
    check("fifo16_single_ar", hs_cnt - hs0, 32'd1);

    // Reset while a request is on the bus.
    ARREADY   = 1'b0;
    FIFO_FREE = 10'd512;
    wait_arvalid("rst_pre_arvalid");
    start_frame($urandom, 2'($urandom));
    check("rst_pre_late", FRAME_LATE, 1'b1);
    ARESET = 1'b1;
    tick();
    check("midrst_arvalid", ARVALID, 1'b0);
    check("midrst_araddr", ARADDR, 32'h0);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_frame_late", FRAME_LATE, 1'b0);
    ARESET = 1'b0;
    exp_q.delete();
    tick(3);
    check("post_rst_arvalid", ARVALID, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
